// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants and types shared by the fetch stage and decode.
// Holds the reset PC, the bubble word, the fetch FSM encoding, the RV32
// base opcodes and a word-alignment helper.
package if_stage_pkg;

    // PC value taken on reset.
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Bubble word: ADDI x0, x0, 0.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of the IF/ID register: {valid, pc, instr}.
    localparam int IF_ID_W = 65;

    // Fetch FSM encoding.
    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // RV32 major opcodes, shared with the decode-stage control unit.
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Force an address onto a word boundary (low two bits cleared).
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if_id_register.sv
// if_id_register: the 65-bit IF/ID pipeline register {valid, pc, instr}.
// flush has priority over hold, hold over load; with none asserted the
// register keeps its value. Asynchronous active-high reset to the bubble
// entry {0, 0, NOP_INSTR}.
module if_id_register
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        hold,
    input  logic        flush,
    input  logic        d_valid,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_instr,
    output logic        q_valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_instr
);

    localparam logic [IF_ID_W-1:0] BUBBLE = {1'b0, 32'h0000_0000, NOP_INSTR};

    logic [IF_ID_W-1:0] entry_r;
    logic [IF_ID_W-1:0] entry_nxt_s;

    // Select the next register contents: flush, hold, load or keep.
    always_comb begin
        entry_nxt_s = entry_r;
        if (flush) begin
            entry_nxt_s = BUBBLE;
        end else if (hold) begin
            entry_nxt_s = entry_r;
        end else if (load) begin
            entry_nxt_s = {d_valid, d_pc, d_instr};
        end else begin
            entry_nxt_s = entry_r;
        end
    end

    // IF/ID storage with asynchronous reset to the bubble entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_r <= BUBBLE;
        end else begin
            entry_r <= entry_nxt_s;
        end
    end

    assign q_valid = entry_r[64];
    assign q_pc    = entry_r[63:32];
    assign q_instr = entry_r[31:0];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the RV32IM 5-stage pipeline.
// Owns the PC, the pending-redirect register and the FETCH/DRAIN FSM, and
// drives the IF/ID register. DRAIN is entered when a redirect arrives while
// a memory access is still in flight: that access cannot be aborted, so its
// word is discarded and the redirect target is fetched once it completes.
// Optional feature macro: IF_STAGE_PERF_COUNT_EN adds perf_fetched and
// perf_stall_cycles counters.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic [31:0] imem_instr,
    input  logic        imem_busywait,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
`ifdef IF_STAGE_PERF_COUNT_EN
    output logic        fetch_stall,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles
`else
    output logic        fetch_stall
`endif
);

    fetch_state_e state_r;
    fetch_state_e state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_nxt_s;
    logic [31:0]  redirect_pc_r;
    logic [31:0]  redirect_pc_nxt_s;
    logic [31:0]  target_s;
    logic         ifid_load_s;
    logic         ifid_hold_s;
    logic         ifid_flush_s;

    assign target_s = word_align(branch_target);

    // Next-state, next-PC and IF/ID control for the fetch FSM.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        redirect_pc_nxt_s = redirect_pc_r;
        ifid_load_s       = 1'b0;
        ifid_hold_s       = 1'b0;
        ifid_flush_s      = 1'b0;
        case (state_r)
            FETCH: begin
                if (branch_taken && !imem_busywait) begin
                    // Redirect immediately; the word returned now is wrong-path.
                    pc_nxt_s     = target_s;
                    ifid_flush_s = 1'b1;
                end else if (branch_taken) begin
                    // Access still in flight: remember target, drain it first.
                    redirect_pc_nxt_s = target_s;
                    ifid_flush_s      = 1'b1;
                    state_nxt_s       = DRAIN;
                end else if (stall) begin
                    // Hold everything; a word returned now is refetched later.
                    ifid_hold_s = 1'b1;
                end else if (imem_busywait) begin
                    ifid_flush_s = 1'b1;
                end else begin
                    ifid_load_s = 1'b1;
                    pc_nxt_s    = pc_r + 32'd4;
                end
            end
            DRAIN: begin
                ifid_flush_s = 1'b1;
                if (branch_taken) begin
                    redirect_pc_nxt_s = target_s;
                end else begin
                    redirect_pc_nxt_s = redirect_pc_r;
                end
                if (!imem_busywait) begin
                    // A redirect arriving on the completing cycle is the
                    // youngest one, so it takes precedence over the stored one.
                    if (branch_taken) begin
                        pc_nxt_s = target_s;
                    end else begin
                        pc_nxt_s = redirect_pc_r;
                    end
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                ifid_flush_s = 1'b1;
                state_nxt_s  = FETCH;
            end
        endcase
    end

    // FSM state, PC and pending-redirect registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            redirect_pc_r <= 32'h0000_0000;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
        end
    end

    if_id_register u_if_id_register (
        .clk     (CLK),
        .rst     (RESET),
        .load    (ifid_load_s),
        .hold    (ifid_hold_s),
        .flush   (ifid_flush_s),
        .d_valid (1'b1),
        .d_pc    (pc_r),
        .d_instr (imem_instr),
        .q_valid (if_id_valid),
        .q_pc    (if_id_pc),
        .q_instr (if_id_instr)
    );

    // The read request follows RESET directly so it drops the moment reset asserts.
    assign imem_read   = ~RESET;
    assign imem_addr   = pc_r;
    assign fetch_stall = (state_r == DRAIN) | imem_busywait;

`ifdef IF_STAGE_PERF_COUNT_EN
    logic [31:0] perf_fetched_r;
    logic [31:0] perf_stall_r;

    // Count valid IF/ID loads and stalled edges, wrapping modulo 2^32.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
        end else begin
            if (ifid_load_s) begin
                perf_fetched_r <= perf_fetched_r + 32'd1;
            end
            if (fetch_stall) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_fetched      = perf_fetched_r;
    assign perf_stall_cycles = perf_stall_r;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven directed bench for if_stage, with hand-written
// sequences for reset state and reset asserted during a pending access.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic [31:0] imem_instr;
    logic        imem_busywait;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        stall;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        fetch_stall;
`ifdef IF_STAGE_PERF_COUNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    if_stage dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .imem_addr     (imem_addr),
        .imem_read     (imem_read),
        .imem_instr    (imem_instr),
        .imem_busywait (imem_busywait),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
`ifdef IF_STAGE_PERF_COUNT_EN
        .fetch_stall       (fetch_stall),
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles)
`else
        .fetch_stall   (fetch_stall)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        stl;
        logic        busy;
        logic [31:0] instr;
        logic [31:0] exp_addr_pre;
        logic        exp_fs;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr_post;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input logic br, input logic [31:0] tgt, input logic stl,
                       input logic busy, input logic [31:0] instr,
                       input logic [31:0] a_pre, input logic fs,
                       input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a_post);
        vec_t t;
        t.br = br; t.tgt = tgt; t.stl = stl; t.busy = busy; t.instr = instr;
        t.exp_addr_pre = a_pre; t.exp_fs = fs; t.exp_valid = v;
        t.exp_instr = ins; t.exp_pc = pc; t.exp_addr_post = a_post;
        vecs.push_back(t);
    endtask

    task automatic apply(input vec_t t, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        branch_taken  = t.br;
        branch_target = t.tgt;
        stall         = t.stl;
        imem_busywait = t.busy;
        imem_instr    = t.instr;
        #1;
        chk({tag, ".addr_pre"}, imem_addr, t.exp_addr_pre);
        chk({tag, ".fetch_stall"}, {31'd0, fetch_stall}, {31'd0, t.exp_fs});
        chk({tag, ".imem_read"}, {31'd0, imem_read}, 32'd1);
        @(posedge CLK);
        #1;
        chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, t.exp_valid});
        chk({tag, ".instr"}, if_id_instr, t.exp_instr);
        chk({tag, ".pc"}, if_id_pc, t.exp_pc);
        chk({tag, ".addr_post"}, imem_addr, t.exp_addr_post);
        n_vec = n_vec + 1;
    endtask

    initial begin
        //  br  tgt            stl  busy instr          a_pre          fs    v     ins            pc             a_post
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00500093, 32'h0,        1'b0, 1'b1, 32'h00500093, 32'h0,        32'h4);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00A00113, 32'h4,        1'b0, 1'b1, 32'h00A00113, 32'h4,        32'h8);
        add(1'b0, 32'h0,       1'b0, 1'b1, 32'hDEADBEEF, 32'h8,        1'b1, 1'b0, NOP,          32'h0,        32'h8);
        add(1'b0, 32'h0,       1'b0, 1'b1, 32'hDEADBEEF, 32'h8,        1'b1, 1'b0, NOP,          32'h0,        32'h8);
        add(1'b0, 32'h0,       1'b0, 1'b1, 32'hDEADBEEF, 32'h8,        1'b1, 1'b0, NOP,          32'h0,        32'h8);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00300193, 32'h8,        1'b0, 1'b1, 32'h00300193, 32'h8,        32'hC);
        // taken branch to 0x103 with memory ready: flush, fetch from 0x100
        add(1'b1, 32'h103,     1'b0, 1'b0, 32'h11111111, 32'hC,        1'b0, 1'b0, NOP,          32'h0,        32'h100);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00100213, 32'h100,      1'b0, 1'b1, 32'h00100213, 32'h100,      32'h104);
        // branch to 0x40 while busy for 2 more cycles: DRAIN, late word dropped
        add(1'b1, 32'h40,      1'b0, 1'b1, 32'hBAD00001, 32'h104,      1'b1, 1'b0, NOP,          32'h0,        32'h104);
        add(1'b0, 32'h0,       1'b0, 1'b1, 32'hBAD00002, 32'h104,      1'b1, 1'b0, NOP,          32'h0,        32'h104);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'hBAD00003, 32'h104,      1'b1, 1'b0, NOP,          32'h0,        32'h40);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00200293, 32'h40,       1'b0, 1'b1, 32'h00200293, 32'h40,       32'h44);
        // second branch during DRAIN replaces the pending target; stall ignored
        add(1'b1, 32'h60,      1'b0, 1'b1, 32'hBAD00004, 32'h44,       1'b1, 1'b0, NOP,          32'h0,        32'h44);
        add(1'b1, 32'h80,      1'b1, 1'b1, 32'hBAD00005, 32'h44,       1'b1, 1'b0, NOP,          32'h0,        32'h44);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'hBAD00006, 32'h44,       1'b1, 1'b0, NOP,          32'h0,        32'h80);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00400313, 32'h80,       1'b0, 1'b1, 32'h00400313, 32'h80,       32'h84);
        // stall together with branch: flush wins
        add(1'b1, 32'h200,     1'b1, 1'b0, 32'h22222222, 32'h84,       1'b0, 1'b0, NOP,          32'h0,        32'h200);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00500393, 32'h200,      1'b0, 1'b1, 32'h00500393, 32'h200,      32'h204);
        // stall alone for two cycles: everything holds
        add(1'b0, 32'h0,       1'b1, 1'b0, 32'h99999999, 32'h204,      1'b0, 1'b1, 32'h00500393, 32'h200,      32'h204);
        add(1'b0, 32'h0,       1'b1, 1'b0, 32'h99999999, 32'h204,      1'b0, 1'b1, 32'h00500393, 32'h200,      32'h204);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00600413, 32'h204,      1'b0, 1'b1, 32'h00600413, 32'h204,      32'h208);
        // PC wrap at 0xFFFFFFFC
        add(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h33333333, 32'h208,     1'b0, 1'b0, NOP,          32'h0,        32'hFFFFFFFC);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00700493, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h00700493, 32'hFFFFFFFC, 32'h0);
        // stall has priority over busywait in FETCH: hold, not bubble
        add(1'b0, 32'h0,       1'b1, 1'b1, 32'h44444444, 32'h0,        1'b1, 1'b1, 32'h00700493, 32'hFFFFFFFC, 32'h0);
        add(1'b0, 32'h0,       1'b0, 1'b0, 32'h00800513, 32'h0,        1'b0, 1'b1, 32'h00800513, 32'h0,        32'h4);

        RESET = 1'b1;
        imem_busywait = 1'b1;
        imem_instr    = 32'h0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        stall         = 1'b0;
        #1;
        chk("rst.imem_read", {31'd0, imem_read}, 32'd0);
        chk("rst.addr", imem_addr, 32'h0);
        chk("rst.valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst.instr", if_id_instr, NOP);
        chk("rst.pc", if_id_pc, 32'h0);
        n_vec = n_vec + 1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // RESET pulsed while an access to 0x4 is pending
        @(negedge CLK);
        imem_busywait = 1'b1;
        imem_instr    = 32'h55555555;
        #1;
        chk("rstmid.addr_before", imem_addr, 32'h4);
        chk("rstmid.fs_before", {31'd0, fetch_stall}, 32'd1);
        #1;
        RESET = 1'b1;
        #1;
        chk("rstmid.valid_now", {31'd0, if_id_valid}, 32'd0);
        chk("rstmid.instr_now", if_id_instr, NOP);
        chk("rstmid.read_now", {31'd0, imem_read}, 32'd0);
        chk("rstmid.addr_now", imem_addr, 32'h0);
        n_vec = n_vec + 1;
        @(posedge CLK);
        @(negedge CLK);
        RESET         = 1'b0;
        imem_busywait = 1'b0;
        imem_instr    = 32'h00900593;
        #1;
        chk("rstmid.read_after", {31'd0, imem_read}, 32'd1);
        chk("rstmid.addr_after", imem_addr, 32'h0);
        @(posedge CLK);
        #1;
        chk("rstmid.valid_after", {31'd0, if_id_valid}, 32'd1);
        chk("rstmid.instr_after", if_id_instr, 32'h00900593);
        chk("rstmid.pc_after", if_id_pc, 32'h0);
        chk("rstmid.addr_next", imem_addr, 32'h4);
        n_vec = n_vec + 1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the RV32IM 5-stage pipeline. It holds the PC, drives the instruction-memory read port, waits on busywait, and applies taken-branch/jump redirects from EX and stalls from the hazard unit. It loads the IF/ID pipeline register whose instruction word feeds the decode-stage control unit directly.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: bubble word (ADDI x0,x0,0) written into IF/ID on flush or fetch stall.
- CLK  input  1  pipeline clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- imem_addr  output  32  fetch address, always equal to the internal PC register.
- imem_read  output  1  read request to instruction memory.
- imem_instr  input  32  instruction word; valid in a cycle where imem_read=1 and imem_busywait=0.
- imem_busywait  input  1  memory not ready. The access in flight cannot be aborted.
- branch_taken  input  1  redirect request from the EX-stage branch control unit.
- branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
- stall  input  1  hazard-unit hold request for the PC and IF/ID.
- if_id_instr  output  32  registered instruction for decode.
- if_id_pc  output  32  registered PC of if_id_instr.
- if_id_valid  output  1  1 = real instruction, 0 = bubble.
- fetch_stall  output  1  combinational; 1 while this stage cannot deliver a valid instruction this cycle.

## Operation
- FSM states:
  - FETCH: normal fetching.
  - DRAIN: a redirect arrived while an access was outstanding; the stage waits for that access to finish and discards its result.
- Reset (asynchronous):
  - PC=RESET_PC, state=FETCH.
  - if_id_instr=NOP_INSTR, if_id_pc=0, if_id_valid=0.
  - redirect_pc=0.
  - imem_read=0 while RESET is high.
- imem_read=1 in both states when RESET is low. imem_addr=PC.
- FETCH, per rising edge, in priority order:
  1. branch_taken=1 and imem_busywait=0: PC←{branch_target[31:2],2'b00}; IF/ID←NOP/valid 0 (flush); stay in FETCH.
  2. branch_taken=1 and imem_busywait=1: redirect_pc←target; IF/ID←NOP/valid 0; go to DRAIN.
  3. stall=1: PC and IF/ID hold. Any word returned this cycle is dropped and refetched.
  4. imem_busywait=1: PC holds; IF/ID←NOP/valid 0 (bubble).
  5. Otherwise: IF/ID←{imem_instr, PC, valid 1}; PC←PC+4.
- DRAIN:
  - IF/ID←NOP/valid 0 every cycle, regardless of stall.
  - A further branch_taken overwrites redirect_pc.
  - When imem_busywait=0: PC←redirect_pc, go to FETCH.
- Flush (branch_taken) overrides stall.
- fetch_stall = (state==DRAIN) | imem_busywait.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. PC[1:0] is always 00.

## Timing
- Hit latency: a word returned with busywait=0 in cycle N appears on if_id_* after edge N.
- Throughput: one instruction per cycle with no stalls.
- Taken-branch penalty: the IF/ID entry at the redirect edge is flushed, then the first target fetch completes at the next edge with busywait=0.
- RESET asserted mid-access: the outstanding access is abandoned, and the first fetch after release is from RESET_PC.
- Outputs go to reset values immediately when RESET asserts, not at the next clock edge.

## Configuration
- IF_STAGE_PERF_COUNT_EN:
  - Defined: adds outputs perf_fetched [31:0], incremented on every valid IF/ID load, and perf_stall_cycles [31:0], incremented on every edge where fetch_stall=1. Both reset to 0 and wrap modulo 2^32.
  - Undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Shared package/header holds the NOP_INSTR constant, the FSM state encoding (FETCH=1'b0, DRAIN=1'b1) and the RV32 opcode constants shared with decode.
- Sub-module if_id_register: a 65-bit register {valid, pc, instr} with load, hold and flush inputs and asynchronous reset to {0, 0, NOP_INSTR}.
- PC register, redirect_pc and the FSM stay in if_stage.

## Test plan
- Reset release, memory always ready, words 0x00500093, 0x00A00113 at 0x0, 0x4: if_id_instr=0x00500093 with pc 0x0 after edge 1 and 0x00A00113 with pc 0x4 after edge 2; valid=1.
- busywait=1 for 3 cycles on the fetch of 0x8: 3 bubbles (valid=0, instr=0x00000013), PC holds at 0x8, fetch_stall=1 for those cycles.
- branch_taken with target 0x103 while memory is ready: IF/ID flushed, next fetch address 0x100.
- branch_taken with target 0x40 while busywait=1 for 2 more cycles: state DRAIN, late word discarded, then fetch from 0x40. A second branch to 0x80 during DRAIN results in a fetch from 0x80.
- stall and branch_taken together: the flush wins. stall alone for 2 cycles: PC and if_id_* unchanged.
- PC=0xFFFFFFFC fetch completes → PC=0x0. RESET pulsed mid-busywait → if_id_valid=0 immediately, first fetch after release from RESET_PC.
